// File: rtl/pc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pc_ctrl_pkg
// Shared definitions for the branch-resolution / program-counter stage:
//   - state_t : PC controller state machine encoding (BOOT, RUN, TRAP)
//   - F3_*    : conditional-branch funct3 encodings
// -----------------------------------------------------------------------------
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_ctrl_if
// Bundles the decode/comparator/fetch/trap signals around the PC controller.
//   master : the surrounding core (drives decode, comparator flags, handshakes)
//   slave  : pc_ctrl (drives PC, redirect decision, trap and statistics)
// Signals:
//   stall, fetch_ready, is_branch, is_jal, is_jalr, funct3, br_less, br_equal,
//   imm, rs1_data, trap_ack                       -> into pc_ctrl
//   br_unsigned, pc, pc_plus4, fetch_valid, taken, illegal_br, trap, trap_pc,
//   branch_cnt, taken_cnt                          <- out of pc_ctrl
// -----------------------------------------------------------------------------
interface pc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             fetch_ready;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic [2:0]       funct3;
    logic             br_less;
    logic             br_equal;
    logic [31:0]      imm;
    logic [31:0]      rs1_data;
    logic             trap_ack;

    logic             br_unsigned;
    logic [31:0]      pc;
    logic [31:0]      pc_plus4;
    logic             fetch_valid;
    logic             taken;
    logic             illegal_br;
    logic             trap;
    logic [31:0]      trap_pc;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output stall, fetch_ready, is_branch, is_jal, is_jalr, funct3,
               br_less, br_equal, imm, rs1_data, trap_ack,
        input  br_unsigned, pc, pc_plus4, fetch_valid, taken, illegal_br,
               trap, trap_pc, branch_cnt, taken_cnt
    );

    modport slave (
        input  stall, fetch_ready, is_branch, is_jal, is_jalr, funct3,
               br_less, br_equal, imm, rs1_data, trap_ack,
        output br_unsigned, pc, pc_plus4, fetch_valid, taken, illegal_br,
               trap, trap_pc, branch_cnt, taken_cnt
    );

endinterface

// File: rtl/pc_ctrl_br_decide.sv
// -----------------------------------------------------------------------------
// br_decide
// Combinational branch-condition decoder.
// Ports:
//   is_branch  in   current instruction is a conditional branch
//   funct3     in   branch funct3
//   br_less    in   comparator less-than result
//   br_equal   in   comparator equality result
//   cond       out  branch condition satisfied
//   illegal_br out  conditional branch with a reserved funct3 (010/011)
// -----------------------------------------------------------------------------
module br_decide
    import pc_ctrl_pkg::*;
(
    input  logic       is_branch,
    input  logic [2:0] funct3,
    input  logic       br_less,
    input  logic       br_equal,
    output logic       cond,
    output logic       illegal_br
);

    always_comb begin
        cond       = 1'b0;
        illegal_br = 1'b0;
        case (funct3)
            F3_BEQ:           cond = br_equal;
            F3_BNE:           cond = !br_equal;
            F3_BLT, F3_BLTU:  cond = br_less;
            F3_BGE, F3_BGEU:  cond = !br_less;
            default:          illegal_br = is_branch;
        endcase
    end

endmodule

// File: rtl/pc_ctrl.sv
// -----------------------------------------------------------------------------
// pc_ctrl
// Branch-resolution and program-counter stage. Resolves the redirect decision
// from the comparator flags and decode, computes the next PC, owns the PC
// register, a boot-delay state machine, a misaligned-target trap handshake and
// the conditional-branch statistics counters.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  pc_ctrl_if.slave (see pc_ctrl_if for the signal list)
// -----------------------------------------------------------------------------
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int          BOOT_CYCLES  = 2,
    parameter int          CNT_W        = 32
)(
    input  logic     clk,
    input  logic     rst,
    pc_ctrl_if.slave bus
);

    localparam logic [3:0]       BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [3:0]       boot_cnt;
    logic [31:0]      pc_q;
    logic             fetch_valid_q;
    logic             trap_q;
    logic [31:0]      trap_pc_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] taken_cnt_q;

    logic        cond;
    logic        illegal_br;
    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] jalr_sum;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        misalign;
    logic        advance;
    logic        count_br;

    br_decide u_br_decide (
        .is_branch  (bus.is_branch),
        .funct3     (bus.funct3),
        .br_less    (bus.br_less),
        .br_equal   (bus.br_equal),
        .cond       (cond),
        .illegal_br (illegal_br)
    );

    // Redirect decision and target; all sums wrap modulo 2^32.
    assign pc_plus4 = pc_q + 32'd4;
    assign jalr_sum = bus.rs1_data + bus.imm;
    assign taken    = bus.is_jal | bus.is_jalr | (bus.is_branch & cond);

    always_comb begin
        if (bus.is_jalr)
            target = jalr_sum & ~32'd1;
        else
            target = pc_q + bus.imm;
    end

    assign next_pc  = taken ? target : pc_plus4;
    assign misalign = taken & target[1];
    assign advance  = !bus.stall & bus.fetch_ready;
    assign count_br = advance & bus.is_branch & !illegal_br & !misalign;

    // State machine, PC, trap capture and statistics counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= BOOT;
            boot_cnt      <= 4'd0;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            trap_q        <= 1'b0;
            trap_pc_q     <= 32'd0;
            branch_cnt_q  <= '0;
            taken_cnt_q   <= '0;
        end else begin
            case (state)
                BOOT: begin
                    boot_cnt <= boot_cnt + 4'd1;
                    if (boot_cnt == BOOT_LAST) begin
                        state         <= RUN;
                        fetch_valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (misalign) begin
                            // Faulting instruction keeps its PC for the handler.
                            state         <= TRAP;
                            trap_q        <= 1'b1;
                            trap_pc_q     <= pc_q;
                            fetch_valid_q <= 1'b0;
                        end else begin
                            pc_q <= next_pc;
                        end
                    end
                    if (count_br) begin
                        branch_cnt_q <= branch_cnt_q + CNT_ONE;
                        if (cond)
                            taken_cnt_q <= taken_cnt_q + CNT_ONE;
                    end
                end
                TRAP: begin
                    if (bus.trap_ack) begin
                        state         <= RUN;
                        pc_q          <= TRAP_VECTOR;
                        trap_q        <= 1'b0;
                        fetch_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state         <= BOOT;
                    boot_cnt      <= 4'd0;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.br_unsigned = bus.funct3[1];
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_plus4;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.taken       = taken;
    assign bus.illegal_br  = illegal_br;
    assign bus.trap        = trap_q;
    assign bus.trap_pc     = trap_pc_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.taken_cnt   = taken_cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_ctrl
// Directed bench for pc_ctrl with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pc_ctrl;
    import pc_ctrl_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    pc_ctrl_if #(.CNT_W(32)) bus ();

    pc_ctrl #(
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .BOOT_CYCLES  (2),
        .CNT_W        (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall     = 1'b0;
        bus.is_branch = 1'b0;
        bus.is_jal    = 1'b0;
        bus.is_jalr   = 1'b0;
        bus.funct3    = 3'b000;
        bus.br_less   = 1'b0;
        bus.br_equal  = 1'b0;
        bus.imm       = 32'd0;
        bus.rs1_data  = 32'd0;
        bus.trap_ack  = 1'b0;
    endtask

    task automatic branch(input logic [2:0] f3, input logic lt, input logic eq, input logic [31:0] im);
        bus.is_branch = 1'b1;
        bus.funct3    = f3;
        bus.br_less   = lt;
        bus.br_equal  = eq;
        bus.imm       = im;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        bus.fetch_ready = 1'b1;
        rst = 1'b1;
        #12;
        check("rst_pc",          bus.pc,          32'h0);
        check("rst_fetch_valid", {31'd0, bus.fetch_valid}, 32'd0);
        check("rst_trap",        {31'd0, bus.trap},        32'd0);
        check("rst_trap_pc",     bus.trap_pc,     32'h0);
        check("rst_branch_cnt",  bus.branch_cnt,  32'd0);
        check("rst_taken_cnt",   bus.taken_cnt,   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Boot delay then sequential fetch.
        step();
        check("boot1_fv", {31'd0, bus.fetch_valid}, 32'd0);
        step();
        check("boot2_fv", {31'd0, bus.fetch_valid}, 32'd1);
        check("run_pc0",  bus.pc, 32'h0);
        check("pc_plus4", bus.pc_plus4, 32'h4);
        step();
        check("run_pc4",  bus.pc, 32'h4);
        step();
        check("run_pc8",  bus.pc, 32'h8);
        step();
        step();
        check("run_pc10", bus.pc, 32'h10);

        // BEQ taken.
        branch(F3_BEQ, 1'b0, 1'b1, 32'h20);
        check("beq_taken",  {31'd0, bus.taken}, 32'd1);
        check("beq_unsign", {31'd0, bus.br_unsigned}, 32'd0);
        step();
        check("beq_pc",     bus.pc, 32'h30);
        check("beq_bcnt",   bus.branch_cnt, 32'd1);
        check("beq_tcnt",   bus.taken_cnt, 32'd1);

        // BNE with equal operands: not taken.
        branch(F3_BNE, 1'b0, 1'b1, 32'h20);
        check("bne_taken", {31'd0, bus.taken}, 32'd0);
        step();
        check("bne_pc",    bus.pc, 32'h34);
        check("bne_bcnt",  bus.branch_cnt, 32'd2);
        check("bne_tcnt",  bus.taken_cnt, 32'd1);

        // br_unsigned follows funct3[1].
        bus.is_branch = 1'b0;
        bus.funct3    = F3_BLTU;
        #1;
        check("bltu_unsign", {31'd0, bus.br_unsigned}, 32'd1);

        // BGE with less set: not taken, counted.
        branch(F3_BGE, 1'b1, 1'b0, 32'h40);
        check("bge_unsign", {31'd0, bus.br_unsigned}, 32'd0);
        check("bge_taken",  {31'd0, bus.taken}, 32'd0);
        step();
        check("bge_pc",    bus.pc, 32'h38);
        check("bge_bcnt",  bus.branch_cnt, 32'd3);
        check("bge_tcnt",  bus.taken_cnt, 32'd1);

        // Stall, then fetch_ready low, during a taken branch.
        branch(F3_BEQ, 1'b0, 1'b1, 32'h40);
        bus.stall = 1'b1;
        #1;
        check("stall_taken", {31'd0, bus.taken}, 32'd1);
        step();
        check("stall_pc",   bus.pc, 32'h38);
        check("stall_bcnt", bus.branch_cnt, 32'd3);
        bus.stall       = 1'b0;
        bus.fetch_ready = 1'b0;
        step();
        check("nrdy_pc",    bus.pc, 32'h38);
        check("nrdy_tcnt",  bus.taken_cnt, 32'd1);
        bus.fetch_ready = 1'b1;
        step();
        check("rel_pc",     bus.pc, 32'h78);
        check("rel_bcnt",   bus.branch_cnt, 32'd4);
        check("rel_tcnt",   bus.taken_cnt, 32'd2);
        idle_inputs();
        step();
        check("after_rel_pc", bus.pc, 32'h7C);

        // Reserved funct3: illegal, falls through, not counted.
        branch(3'b011, 1'b1, 1'b1, 32'h100);
        check("ill_flag",  {31'd0, bus.illegal_br}, 32'd1);
        check("ill_taken", {31'd0, bus.taken}, 32'd0);
        step();
        check("ill_pc",    bus.pc, 32'h80);
        check("ill_bcnt",  bus.branch_cnt, 32'd4);
        idle_inputs();

        // JALR to misaligned target 0x106 traps.
        bus.is_jalr  = 1'b1;
        bus.rs1_data = 32'h103;
        bus.imm      = 32'h4;
        #1;
        check("jalr_taken", {31'd0, bus.taken}, 32'd1);
        step();
        check("trap_flag",  {31'd0, bus.trap}, 32'd1);
        check("trap_pc",    bus.trap_pc, 32'h80);
        check("trap_hold",  bus.pc, 32'h80);
        check("trap_fv",    {31'd0, bus.fetch_valid}, 32'd0);
        idle_inputs();
        step();
        check("trap_wait",  {31'd0, bus.trap}, 32'd1);
        bus.trap_ack = 1'b1;
        step();
        check("ack_pc",     bus.pc, 32'h100);
        check("ack_trap",   {31'd0, bus.trap}, 32'd0);
        check("ack_fv",     {31'd0, bus.fetch_valid}, 32'd1);
        check("ack_bcnt",   bus.branch_cnt, 32'd4);
        check("ack_tcnt",   bus.taken_cnt, 32'd2);
        // trap_ack held into RUN has no effect.
        step();
        check("ack_run_pc", bus.pc, 32'h104);
        bus.trap_ack = 1'b0;
        step();
        check("pc108",      bus.pc, 32'h108);

        // JAL with negative offset to top of memory, then wrap to 0.
        bus.is_jal = 1'b1;
        bus.imm    = 32'hFFFF_FEF4;
        #1;
        step();
        check("jal_top",  bus.pc, 32'hFFFF_FFFC);
        idle_inputs();
        step();
        check("wrap_pc",  bus.pc, 32'h0);

        // JALR wins over JAL when both set.
        bus.is_jal   = 1'b1;
        bus.is_jalr  = 1'b1;
        bus.rs1_data = 32'h200;
        bus.imm      = 32'h10;
        #1;
        step();
        check("prio_pc",  bus.pc, 32'h210);
        idle_inputs();

        // Reset asserted while in TRAP.
        bus.is_jalr  = 1'b1;
        bus.rs1_data = 32'h2;
        #1;
        step();
        check("trap2_flag", {31'd0, bus.trap}, 32'd1);
        idle_inputs();
        rst = 1'b1;
        #1;
        check("rtrap_trap",   {31'd0, bus.trap}, 32'd0);
        check("rtrap_pc",     bus.pc, 32'h0);
        check("rtrap_trappc", bus.trap_pc, 32'h0);
        check("rtrap_bcnt",   bus.branch_cnt, 32'd0);
        check("rtrap_tcnt",   bus.taken_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted during BOOT, then a full boot sequence.
        step();
        step();
        check("boot_b_fv", {31'd0, bus.fetch_valid}, 32'd1);
        step();
        check("boot_b_pc", bus.pc, 32'h4);
        rst = 1'b1;
        #1;
        check("rrun_pc", bus.pc, 32'h0);
        check("rrun_fv", {31'd0, bus.fetch_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("rboot_fv", {31'd0, bus.fetch_valid}, 32'd0);
        check("rboot_pc", bus.pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("reboot1_fv", {31'd0, bus.fetch_valid}, 32'd0);
        step();
        check("reboot2_fv", {31'd0, bus.fetch_valid}, 32'd1);
        step();
        check("reboot_pc4", bus.pc, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
